// File: rtl/adc_avg_filter.sv
// adc_avg_filter: per-channel moving average over one tagged ADC sample stream.
// Ports: clk, rst_n, in_valid/in_ch/in_data, flush -> out_valid/out_ch/out_data, primed, err_ch.
module adc_avg_filter #(
  parameter int DATA_W   = 12,
  parameter int LOG2_WIN = 3,
  parameter int CHANNELS = 4,
  parameter int ROUND    = 0,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                flush,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic [DATA_W-1:0]   out_data,
  output logic [CHANNELS-1:0] primed,
  output logic                err_ch
);

  localparam int WIN   = 1 << LOG2_WIN;
  localparam int SUM_W = DATA_W + LOG2_WIN;
  localparam logic [SUM_W:0] RND =
    (ROUND != 0) ? (SUM_W+1)'(WIN / 2) : '0;
  localparam logic [SUM_W:0] MAXV =
    {{(LOG2_WIN+1){1'b0}}, {DATA_W{1'b1}}};

  // Samples are held off until the released reset has passed two flops.
  logic [1:0] rst_q;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_q <= '0;
    else        rst_q <= {rst_q[0], 1'b1};
  end

  assign run = rst_q[1];

  logic [CH_W:0] ch_ext;
  logic          in_bad;
  logic          take;

  assign ch_ext = {1'b0, in_ch};
  assign in_bad = ch_ext >= (CH_W+1)'(CHANNELS);
  assign take   = in_valid & run & ~flush;

  // Stage 1: registered sample
  logic              s1_vld;
  logic              s1_err;
  logic [CH_W-1:0]   s1_ch;
  logic [DATA_W-1:0] s1_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_err  <= 1'b0;
      s1_ch   <= '0;
      s1_data <= '0;
    end else begin
      s1_vld  <= take & ~in_bad;
      s1_err  <= take & in_bad;
      s1_ch   <= in_ch;
      s1_data <= in_data;
    end
  end

  // Channel state is updated in stage order, one sample per cycle,
  // so a back-to-back sample on the same channel sees fresh state.
  logic [DATA_W-1:0]   hist [CHANNELS][WIN];
  logic [LOG2_WIN-1:0] ptr  [CHANNELS];
  logic [SUM_W-1:0]    sum  [CHANNELS];
  logic [CHANNELS-1:0] prm;

  logic [DATA_W-1:0] old;
  logic [SUM_W-1:0]  new_sum;
  logic [SUM_W:0]    rsum;
  logic [SUM_W:0]    quo;
  logic [DATA_W-1:0] res;

  always_comb begin
    old  = hist[s1_ch][ptr[s1_ch]];
    if (!prm[s1_ch])
      new_sum = {s1_data, {LOG2_WIN{1'b0}}};
    else
      new_sum = sum[s1_ch] - SUM_W'(old)
              + SUM_W'(s1_data);
    rsum = {1'b0, new_sum} + RND;
    quo  = rsum >> LOG2_WIN;
    if (!prm[s1_ch])   res = s1_data;
    else if (quo > MAXV) res = '1;
    else                 res = quo[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prm <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        ptr[c] <= '0;
        sum[c] <= '0;
        for (int w = 0; w < WIN; w++)
          hist[c][w] <= '0;
      end
    end else if (flush) begin
      prm <= '0;
      for (int c = 0; c < CHANNELS; c++)
        ptr[c] <= '0;
    end else if (s1_vld) begin
      sum[s1_ch] <= new_sum;
      if (!prm[s1_ch]) begin
        prm[s1_ch] <= 1'b1;
        ptr[s1_ch] <= '0;
        for (int w = 0; w < WIN; w++)
          hist[s1_ch][w] <= s1_data;
      end else begin
        hist[s1_ch][ptr[s1_ch]] <= s1_data;
        ptr[s1_ch] <= ptr[s1_ch] + 1'b1;
      end
    end
  end

  // Stage 2: result register
  logic              s2_vld;
  logic              s2_err;
  logic [CH_W-1:0]   s2_ch;
  logic [DATA_W-1:0] s2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld  <= 1'b0;
      s2_err  <= 1'b0;
      s2_ch   <= '0;
      s2_data <= '0;
    end else begin
      s2_vld  <= s1_vld & ~flush;
      s2_err  <= s1_err & ~flush;
      s2_ch   <= s1_ch;
      s2_data <= res;
    end
  end

  // Outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      err_ch    <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      primed    <= '0;
    end else begin
      out_valid <= s2_vld & ~flush;
      err_ch    <= s2_err & ~flush;
      if (flush) begin
        primed <= '0;
      end else if (s2_vld) begin
        out_ch         <= s2_ch;
        out_data       <= s2_data;
        primed[s2_ch]  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/adc_avg_filter.md
# adc_avg_filter

Multi-channel, parametrised moving-average filter for the printer's ADC inputs: thermistor channels, bed and hotend. Samples from a shared ADC front-end arrive as one tagged stream, one sample per cycle at most. The block keeps a separate circular history and running sum for each channel. For every accepted sample it emits the channel's window average, tagged with the channel number, two cycles later. It sits between the ADC sequencer and the temperature control loops.

## Interface
Parameters:
- DATA_W, 12: sample and output width in bits.
- LOG2_WIN, 3: log2 of the window length; window WIN = 2^LOG2_WIN. Legal range is 1..6.
- CHANNELS, 4: number of independent channels. Legal range is 1..16.
- ROUND, 0: 0 = floor division; 1 = round half up (add WIN/2 before the shift).
- CH_W (derived): clog2(CHANNELS), minimum 1.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: sample strobe.
- in_ch, input, CH_W: channel tag of the sample.
- in_data, input, DATA_W: unsigned sample.
- flush, input, 1: synchronous re-prime of all channels.
- out_valid, output, 1: one-cycle result strobe.
- out_ch, output, CH_W: channel of the result.
- out_data, output, DATA_W: window average.
- primed, output, CHANNELS: per-channel flag; bit c = 1 once channel c has accepted its first sample.
- err_ch, output, 1: one-cycle pulse when a sample with in_ch >= CHANNELS is dropped.

## Operation
Per-channel state:
- History: WIN entries of DATA_W.
- Write pointer: LOG2_WIN bits, wraps WIN-1 -> 0.
- Running sum: SUM_W = DATA_W + LOG2_WIN bits. It never overflows, because sum <= WIN*(2^DATA_W - 1).
- primed bit.

Accepted sample = in_valid = 1, in_ch < CHANNELS, flush = 0.

First sample on an unprimed channel (priming):
- Fill all WIN history entries with in_data.
- sum = in_data << LOG2_WIN; pointer = 0.
- Set primed[c].
- out_data = in_data.
- History may be filled over WIN cycles in the background, but results must be as if the fill were instant.

Later samples:
- old = history[c][ptr[c]].
- sum = sum - old + in_data.
- history[c][ptr[c]] = in_data; ptr[c] increments.
- out_data = (sum + (ROUND ? WIN/2 : 0)) >> LOG2_WIN, truncated to DATA_W. With ROUND = 1, the result at the upper limit saturates to 2^DATA_W - 1 rather than wrapping.

Output rules:
- Results must equal the sequential definition above for any interleaving of channels. This includes back-to-back samples on the same channel; use forwarding or bypass, never stalls. No input backpressure exists.
- Out-of-range tag: the sample is dropped, no out_valid, err_ch pulses at the same latency as a result, and no state changes.

Flush:
- Clears all primed bits and all pointers. Sums are redefined by the next priming sample.
- Samples still in the pipeline when flush is asserted produce no out_valid.
- A sample presented in the same cycle as flush is discarded.
- The cycle after flush, a sample is treated as a priming sample.

Reset (asynchronous, at any time, including mid-pipeline):
- Returns all state to reset values and discards in-flight samples.
- Reset values: out_valid = 0, out_ch = 0, out_data = 0, primed = 0, err_ch = 0, pointers = 0, sums = 0.

## Timing
- Latency 2: a sample accepted at edge N produces out_valid, out_ch, out_data registered at edge N+2.
- Throughput: 1 sample per clock, sustained, any channel sequence.
- out_valid and err_ch are single-cycle pulses and mutually exclusive.
- primed[c] updates at the same edge as the corresponding out_valid.
- Outputs are registered; out_data and out_ch hold their last value while out_valid = 0.
- rst_n deassertion is synchronised internally (2-flop). The first sample may be presented 2 cycles after rst_n rises.

## Test plan
- **Priming and averaging**: DATA_W=12, LOG2_WIN=3, ROUND=0. Ch0 samples 100, then 180 repeated 8 times.
  - Outputs: 100, 110, 120, 130, 140, 150, 160, 170, 180.
  - primed[0] = 1 from the first result.
- **Interleaved back-to-back**: consecutive cycles ch1=4000, ch1=0, ch2=8, ch1=0.
  - Outputs 2 cycles later, in order: (1,4000), (1,3500), (2,8), (1,3000).
  - Checks same-channel forwarding.
- **Rounding**: ROUND=1, ch3 primed with 0, then sample 4.
  - sum=4, output (4+4)>>3 = 1. With ROUND=0 the output is 0.
  - Full-scale 4095 steady gives output 4095 with no wrap.
- **Bad channel**: CHANNELS=3, in_ch=3, in_data=50.
  - err_ch pulses at N+2, no out_valid.
  - Subsequent ch0 results are unaffected.
- **Flush mid-stream**: ch0 at 200 steady.
  - Assert flush while one sample is in flight, with in_valid high in the same cycle. No output for either sample; primed = 0.
  - The next ch0 sample of 40 outputs 40.
- **Reset mid-operation**: drop rst_n asynchronously between clock edges during a stream.
  - All outputs go to zero immediately.
  - After release and sync delay, the first sample per channel re-primes.
